// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and device replies.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // Odd parity bit: makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers on both pins, glitch filter on the clock,
// and one-cycle fall/rise strobes of the filtered clock. Shared with the receive path.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_filt,
    output logic data_sync,
    output logic fall,
    output logic rise
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_ff;
    logic [1:0]    data_ff;
    logic [CW-1:0] cnt;

    assign data_sync = data_ff[1];

    // Synchronizers; reset to the idle (released, pulled-up) level so no false edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], clk_raw};
            data_ff <= {data_ff[0], data_raw};
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            cnt      <= '0;
            fall     <= 1'b0;
            rise     <= 1'b0;
        end else begin
            fall <= 1'b0;
            rise <= 1'b0;
            if (clk_ff[1] != clk_filt) begin
                if (cnt == CNT_LAST) begin
                    clk_filt <= clk_ff[1];
                    cnt      <= '0;
                    fall     <= ~clk_ff[1];
                    rise     <= clk_ff[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits + odd parity + stop clocked
// out on device clock falls, then ACK check. Open-drain lines are driven only low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;

    logic clk_filt;
    logic data_sync;
    logic clk_fall;
    logic clk_rise_unused;
    logic timed;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .clk_raw   (ps2_clk_in),
        .data_raw  (ps2_data_in),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .fall      (clk_fall),
        .rise      (clk_rise_unused)
    );

    // Timeout window covers the whole device-clocked part of the transfer.
    assign timed = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

    // Transmit FSM with registered line enables and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timed && (to_cnt == TO_LAST)) begin
                // Device stopped clocking: give both lines back and abort.
                state       <= IDLE;
                tx_busy     <= 1'b0;
                tx_error    <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                if (timed) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        tx_busy     <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_start) begin
                            shreg      <= {1'b1, odd_parity(tx_data), tx_data};
                            inh_cnt    <= INH_LOAD;
                            tx_busy    <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == '0) begin
                            ps2_data_oe <= 1'b1;
                            state       <= REQ;
                        end else begin
                            inh_cnt <= inh_cnt - 1'b1;
                        end
                    end
                    REQ: begin
                        // Start bit stays driven low while the clock is handed to the device.
                        ps2_clk_oe <= 1'b0;
                        bit_cnt    <= '0;
                        to_cnt     <= '0;
                        state      <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_fall) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= {1'b1, shreg[9:1]};
                            bit_cnt     <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state <= WAIT_IDLE;
                            end else begin
                                tx_error <= 1'b1;
                                tx_busy  <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_filt && data_sync) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        tx_busy     <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard model on the shared lines.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 10;
    localparam int unsigned FL   = 2;
    localparam int unsigned TO   = 2000;
    localparam int          HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int inh_run  = 0;
    int inh_len  = 0;
    int dev_pulse = -1;

    // Wired-AND of the open-drain lines with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse counters and inhibit-length measurement, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) begin
            inh_run++;
        end else if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) begin
            if (inh_run != 0) inh_len = inh_run;
            inh_run = 0;
        end else begin
            inh_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check_eq("busy_on_accept", {31'd0, tx_busy}, 32'd1);
    endtask

    // Keyboard model: waits for the start bit, then gives 11 clocks, sampling on rising edges.
    task automatic device_frame(input bit ack, output logic [9:0] bits);
        int w;
        w = 0;
        bits = '0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            check_eq("request_seen", 32'd0, 32'd1);
        end else begin
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                dev_pulse = i;
                if (i == 10 && ack) dev_data_low = 1'b1;
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                if (i < 10) bits[i] = ps2_data_in;
                repeat (HALF) @(negedge clk);
            end
            dev_data_low = 1'b0;
        end
        dev_pulse = -1;
    endtask

    task automatic wait_not_busy();
        int w;
        w = 0;
        while (tx_busy === 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_eq("return_idle", {31'd0, tx_busy}, 32'd0);
    endtask

    // Full acked transfer of one byte with frame, pulse and inhibit-length checks.
    task automatic acked_frame(input string tag, input logic [7:0] d, input logic [9:0] exp_frame);
        logic [9:0] bits;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        inh_len = 0;
        start_tx(d);
        device_frame(1'b1, bits);
        wait_not_busy();
        repeat (5) @(negedge clk);
        check_eq({tag, "_frame"}, {22'd0, bits}, {22'd0, exp_frame});
        check_eq({tag, "_done"}, done_cnt - d0, 32'd1);
        check_eq({tag, "_err"}, err_cnt - e0, 32'd0);
        check_eq({tag, "_inhibit"}, inh_len, INH);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, e0, w, n;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("rst_done", {31'd0, tx_done}, 32'd0);
        check_eq("rst_error", {31'd0, tx_error}, 32'd0);
        check_eq("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Hand-computed frames {stop, parity, data}.
        acked_frame("ed", CMD_SET_LEDS, 10'h3ED);
        acked_frame("x07", 8'h07, 10'h207);
        acked_frame("x00", 8'h00, 10'h300);

        // Device does not ACK.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(CMD_RESET);
        device_frame(1'b0, bits);
        repeat (10) @(negedge clk);
        check_eq("noack_err", err_cnt - e0, 32'd1);
        check_eq("noack_done", done_cnt - d0, 32'd0);
        check_eq("noack_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("noack_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("noack_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("noack_frame", {22'd0, bits}, {22'd0, 10'h3FF});

        // Device never clocks: timeout counted from the first SHIFT cycle.
        start_tx(CMD_ENABLE);
        w = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("to_shift_entry", {31'd0, ps2_data_oe}, 32'd1);
        n = 0;
        while (tx_error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles", n, TO);
        check_eq("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check_eq("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check_eq("to_busy", {31'd0, tx_busy}, 32'd0);
        repeat (5) @(negedge clk);
        acked_frame("after_to", CMD_SET_LEDS, 10'h3ED);

        // Start request during SHIFT is ignored and tx_data changes do not leak in.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(CMD_ENABLE);
        fork
            device_frame(1'b1, bits);
            begin
                w = 0;
                while (dev_pulse != 3 && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(negedge clk);
                tx_data  = CMD_RESET;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_not_busy();
        repeat (30) @(negedge clk);
        check_eq("busy_ign_frame", {22'd0, bits}, {22'd0, 10'h2F4});
        check_eq("busy_ign_done", done_cnt - d0, 32'd1);
        check_eq("busy_ign_err", err_cnt - e0, 32'd0);
        check_eq("busy_ign_no_queue", {31'd0, tx_busy}, 32'd0);
        check_eq("busy_ign_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);

        // Asynchronous reset while bit 4 (a 0) of 0xED is being driven.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(CMD_SET_LEDS);
        fork
            device_frame(1'b1, bits);
            begin
                w = 0;
                while (dev_pulse != 4 && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                repeat (8) @(negedge clk);
                check_eq("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
                #2 rst = 1'b1;
                #1;
                check_eq("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                check_eq("mid_rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                check_eq("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check_eq("mid_rst_done", done_cnt - d0, 32'd0);
        check_eq("mid_rst_err", err_cnt - e0, 32'd0);
        check_eq("mid_rst_idle_busy", {31'd0, tx_busy}, 32'd0);

        check_eq("done_and_error_overlap", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
